fdd140_track_buffer: RTL
========================

// Module: fdd140_track_buffer
// PURPOSE
//  Track RAM plus rotating-head model for the 140K drive. The SD loader fills it with a
//  whole track of nibbles: 13 sectors x 512 = 6656 bytes, via wr_addr/wr_data/wr_en.
//  The read side emulates a spinning disk. A head pointer advances one byte every
//  BYTE_CYCLES CPU clocks and wraps at TRACK_LEN. Each byte lands in a data latch that
//  the controller samples, Disk-II style (bit 7 = byte valid).
// PARAMETERS
//  ADDR_W       13    track RAM address width (2**ADDR_W bytes)
//  TRACK_LEN    6656  bytes per track; head wraps at TRACK_LEN-1
//  BYTE_CYCLES  32    cpu_ce pulses per byte (8 bits x 4 us at 1 MHz)
// PORTS
//  clk         in   1       system clock
//  nreset      in   1       asynchronous, active-low reset
//  cpu_ce      in   1       one-clk-wide CPU clock enable pulse
//  motor_on    in   1       drive motor; 0 freezes rotation
//  load_busy   in   1       1 while the SD loader rewrites the track
//  wr_addr     in   ADDR_W  loader write address
//  wr_data     in   8       loader write data
//  wr_en       in   1       loader write strobe, one byte per clk
//  rd_strobe   in   1       one-clk pulse: CPU has read the data latch
//  rd_data     out  8       data latch contents
//  head_pos    out  ADDR_W  current byte index under the head
//  index_pulse out  1       one-clk pulse when head wraps to 0
// BEHAVIOUR
//  Reset: rd_data=8'h00, head_pos=0, index_pulse=0, byte timer=0, rd_pending=0. RAM contents undefined.
//  RAM: 2**ADDR_W x 8, synchronous write port and synchronous read port.
//   - A write to address X always lands (wr_en is honoured even when load_busy=0).
//   - Same-cycle read and write of X: read-first, returns the old data.
//  Rotation enable: rot_en = motor_on & ~load_busy.
//  Byte timer (0..BYTE_CYCLES-1):
//   - Counts cpu_ce while rot_en=1; holds when rot_en=0.
//   - On cpu_ce with timer==BYTE_CYCLES-1: timer<=0 and head advances.
//  Head advance:
//   - head_pos <= (head_pos==TRACK_LEN-1) ? 0 : head_pos+1.
//   - index_pulse=1 for exactly the clk in which head_pos becomes 0 by wrap.
//  Latch load: RAM read addr = head_pos. One clk after any head_pos change, rd_pending
//   is set. The next clk loads rd_data <= ram_q and clears rd_pending. Latency from head
//   advance to rd_data update = 2 clk.
//  rd_strobe: clears rd_data[7] only (rd_data <= {1'b0, rd_data[6:0]}). Never moves the head.
//  Simultaneous latch load and rd_strobe: load wins; the new byte keeps bit 7 set.
//  load_busy rising edge (registered copy): head_pos<=0, timer<=0, rd_data<=8'h00,
//   rd_pending<=0, no index_pulse. Through load_busy=1: rd_data stays 8'h00 and rd_strobe is ignored.
//  load_busy falling edge: rd_pending is set, so byte 0 reaches the latch 2 clk later and
//   rotation resumes from head_pos=0.
//  motor_on=0: timer and head freeze, rd_data holds its value, rd_strobe still clears bit 7.
//  TRACK_LEN > 2**ADDR_W is illegal; flag it with an elaboration-time check.
// STRUCTURE
//  Shared package fdd140_pkg: FDD_TRACK_LEN=6656, FDD_SECT_PER_TRK=13,
//   FDD_ADDR_W=13, FDD_BYTE_CYCLES=32.
//  Sub-module fdd140_track_ram: simple dual-port, read-first, inferable as block RAM.
//  The top level holds the byte timer, head counter, load_busy edge detect, and latch FSM
//   (IDLE, PEND, LOAD; LOAD returns to IDLE).
// TESTING
//  1 Fill 0..6655 with addr[7:0]|8'h80, drop load_busy, motor_on=1 -> after 2 clk rd_data=8'h80;
//    after 32 cpu_ce head_pos=1, and 2 clk later rd_data=8'h81.
//  2 Run 6656*32 cpu_ce -> head_pos goes 6655->0 once, index_pulse high exactly 1 clk,
//    rd_data=8'h80 again.
//  3 rd_strobe with rd_data=8'h93 -> rd_data=8'h13. rd_strobe in the same clk as a latch
//    load of 8'h94 -> rd_data=8'h94.
//  4 Raise load_busy at head_pos=1234 -> next clk head_pos=0, rd_data=8'h00. rd_strobe and
//    cpu_ce are ignored while busy.
//  5 Hold motor_on=0 for 500 cpu_ce -> head_pos, timer, and rd_data unchanged. Restore
//    motor_on=1 -> advance resumes at the saved timer value.
//  6 Assert nreset mid-rotation (head_pos=4000, timer=17) -> asynchronously
//    rd_data=8'h00, head_pos=0, index_pulse=0.

Source files
------------

// File: rtl/fdd140_pkg.sv
// Shared constants and types for the 140K drive emulation.
// Contents:
//   FDD_* geometry and timing constants (13 sectors x 512 nibble bytes per track)
//   latch_state_t  - data latch FSM encoding
//   fdd140_dbg_t   - debug view of the track buffer internals
//   clear_valid()  - drops the Disk-II "byte valid" flag (bit 7)
package fdd140_pkg;

  localparam int FDD_SECT_PER_TRK = 13;
  localparam int FDD_SECT_BYTES   = 512;
  localparam int FDD_TRACK_LEN    = FDD_SECT_PER_TRK * FDD_SECT_BYTES;  // 6656
  localparam int FDD_ADDR_W       = 13;
  localparam int FDD_BYTE_CYCLES  = 32;   // 8 bits x 4 us at 1 MHz

  typedef enum logic [1:0] {
    LATCH_IDLE = 2'd0,   // latch holds its byte
    LATCH_PEND = 2'd1,   // head moved; RAM read of the new position in flight
    LATCH_LOAD = 2'd2    // ram_q valid; latch loads at the end of this state
  } latch_state_t;

  typedef struct packed {
    latch_state_t state;
    logic         rd_pending;
    logic [7:0]   timer;
    logic         busy_q;
  } fdd140_dbg_t;

  function automatic logic [7:0] clear_valid(input logic [7:0] b);
    return {1'b0, b[6:0]};
  endfunction

endpackage

// File: rtl/fdd140_track_buffer_if.sv
// Bus between the drive controller / SD loader and the track buffer.
// Handshake: there is no valid/ready pair here. wr_en writes one byte per clk
// with no back-pressure; cpu_ce and rd_strobe are single-clk pulses that are
// acted on in the clk they are high; rd_data/head_pos/index_pulse are plain
// registered outputs that the controller samples whenever it likes.
//   master : controller + loader side (drives cpu_ce, motor_on, load_busy,
//            wr_addr, wr_data, wr_en, rd_strobe)
//   slave  : track buffer side (drives rd_data, head_pos, index_pulse)
interface fdd140_track_buffer_if
  import fdd140_pkg::*;
#(
  parameter int ADDR_W = FDD_ADDR_W
);

  logic              cpu_ce;
  logic              motor_on;
  logic              load_busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              rd_strobe;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] head_pos;
  logic              index_pulse;

  modport master (
    output cpu_ce, motor_on, load_busy, wr_addr, wr_data, wr_en, rd_strobe,
    input  rd_data, head_pos, index_pulse
  );

  modport slave (
    input  cpu_ce, motor_on, load_busy, wr_addr, wr_data, wr_en, rd_strobe,
    output rd_data, head_pos, index_pulse
  );

endinterface

// File: rtl/fdd140_track_ram.sv
// Simple dual-port track RAM, 2**ADDR_W x 8, one write port and one read port,
// both synchronous. Read-first: a same-cycle read and write of one address
// returns the old contents. No reset, so it maps onto block RAM.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data  write port
//   rd_addr          read address, sampled every clk
//   rd_q             read data, one clk after rd_addr
module fdd140_track_ram
  import fdd140_pkg::*;
#(
  parameter int ADDR_W = FDD_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_q
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/fdd140_track_buffer.sv
// Track RAM plus rotating-head model for the 140K drive.
// The SD loader writes a whole track of nibbles into the RAM; the read side
// emulates a spinning disk: the head advances one byte every BYTE_CYCLES
// cpu_ce pulses, wraps at TRACK_LEN, and each byte under the head lands in a
// Disk-II style data latch (bit 7 = byte valid).
// Ports:
//   clk, nreset  clock, asynchronous active-low reset
//   bus          fdd140_track_buffer_if.slave (cpu_ce, motor_on, load_busy,
//                wr_*, rd_strobe in; rd_data, head_pos, index_pulse out)
//   dbg          latch FSM state, rd_pending, byte timer, registered load_busy
module fdd140_track_buffer
  import fdd140_pkg::*;
#(
  parameter int ADDR_W      = FDD_ADDR_W,
  parameter int TRACK_LEN   = FDD_TRACK_LEN,
  parameter int BYTE_CYCLES = FDD_BYTE_CYCLES
) (
  input  logic                   clk,
  input  logic                   nreset,
  fdd140_track_buffer_if.slave   bus,
  output fdd140_dbg_t            dbg
);

  if (TRACK_LEN > (2 ** ADDR_W) || TRACK_LEN < 2) begin : g_bad_track_len
    $error("fdd140_track_buffer: TRACK_LEN=%0d does not fit ADDR_W=%0d", TRACK_LEN, ADDR_W);
  end
  if (BYTE_CYCLES < 1 || BYTE_CYCLES > 256) begin : g_bad_byte_cycles
    $error("fdd140_track_buffer: BYTE_CYCLES=%0d outside 1..256", BYTE_CYCLES);
  end

  localparam logic [ADDR_W-1:0] HEAD_LAST  = ADDR_W'(TRACK_LEN - 1);
  localparam logic [7:0]        TIMER_LAST = 8'(BYTE_CYCLES - 1);

  logic              busy_q;
  logic              busy_rise;
  logic              busy_fall;
  logic              rot_en;
  logic              head_adv;
  logic [7:0]        timer_q;
  logic [ADDR_W-1:0] head_q;
  logic              index_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        ram_q;
  latch_state_t      state_q;
  latch_state_t      state_d;
  logic              load_latch;
  logic              rd_pending;

  // Edge detect against the registered copy so the reaction happens in the
  // same clk that load_busy is first seen high (or low).
  assign busy_rise = bus.load_busy & ~busy_q;
  assign busy_fall = ~bus.load_busy & busy_q;
  assign rot_en    = bus.motor_on & ~bus.load_busy;
  assign head_adv  = rot_en & bus.cpu_ce & (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) busy_q <= 1'b0;
    else         busy_q <= bus.load_busy;
  end

  // Byte timer and head counter. A fresh load restarts the disk at byte 0.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer_q <= '0;
      head_q  <= '0;
      index_q <= 1'b0;
    end else begin
      index_q <= head_adv & (head_q == HEAD_LAST);
      if (busy_rise) begin
        timer_q <= '0;
        head_q  <= '0;
      end else if (rot_en && bus.cpu_ce) begin
        if (head_adv) begin
          timer_q <= '0;
          head_q  <= (head_q == HEAD_LAST) ? '0 : head_q + ADDR_W'(1);
        end else begin
          timer_q <= timer_q + 8'd1;
        end
      end
    end
  end

  fdd140_track_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (head_q),
    .rd_q    (ram_q)
  );

  // Latch FSM: state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= LATCH_IDLE;
    else         state_q <= state_d;
  end

  // Latch FSM: next state. After a head move the RAM needs one clk to present
  // the new byte (PEND), then the latch loads (LOAD). On the busy falling edge
  // the head already sits at 0 and ram_q already holds byte 0, so PEND is skipped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LATCH_IDLE: state_d = LATCH_IDLE;
      LATCH_PEND: state_d = LATCH_LOAD;
      LATCH_LOAD: state_d = LATCH_IDLE;
      default:    state_d = LATCH_IDLE;
    endcase
    if (busy_rise)      state_d = LATCH_IDLE;
    else if (busy_fall) state_d = LATCH_LOAD;
    else if (head_adv)  state_d = LATCH_PEND;
  end

  // Latch FSM: outputs
  always_comb begin
    load_latch = 1'b0;
    rd_pending = 1'b0;
    if (state_q == LATCH_LOAD) begin
      load_latch = 1'b1;
      rd_pending = 1'b1;
    end
  end

  // Data latch. A load beats a simultaneous rd_strobe so a fresh byte is
  // never seen with its valid bit already cleared.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_data_q <= 8'h00;
    end else if (busy_rise) begin
      rd_data_q <= 8'h00;
    end else if (load_latch) begin
      rd_data_q <= ram_q;
    end else if (bus.rd_strobe && !bus.load_busy) begin
      rd_data_q <= clear_valid(rd_data_q);
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.head_pos    = head_q;
  assign bus.index_pulse = index_q;

  always_comb begin
    dbg            = '0;
    dbg.state      = state_q;
    dbg.rd_pending = rd_pending;
    dbg.timer      = timer_q;
    dbg.busy_q     = busy_q;
  end

endmodule
